// File: rtl/pcpi_issue_ctrl.sv
// PCPI issue controller: hands one core request at a time to a coprocessor and returns its result.
// Optional watchdog that traps a silent coprocessor is enabled by defining PCPI_TIMEOUT_EN.
module pcpi_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic        resp_wr,
  output logic        resp_trap,
  output logic [31:0] resp_rd,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state;
  logic   timeout_hit;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rd    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            pcpi_insn  <= req_insn;
            pcpi_rs1   <= req_rs1;
            pcpi_rs2   <= req_rs2;
            pcpi_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Flush outranks both a same-cycle completion and a watchdog expiry.
          if (flush) begin
            pcpi_valid <= 1'b0;
            state      <= IDLE;
          end else if (pcpi_ready) begin
            resp_wr    <= pcpi_wr;
            resp_rd    <= pcpi_rd;
            resp_valid <= 1'b1;
            pcpi_valid <= 1'b0;
            state      <= DONE;
          end else if (timeout_hit) begin
            resp_valid <= 1'b1;
            pcpi_valid <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          pcpi_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef PCPI_TIMEOUT_EN
  logic [7:0] timeout_cnt;

  assign timeout_hit = (state == ISSUE) && !flush && !pcpi_ready && !pcpi_wait &&
                       (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Counts consecutive ISSUE cycles in which the coprocessor neither stalls nor answers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_cnt <= '0;
      resp_trap   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        timeout_cnt <= '0;
      end else if (state == ISSUE) begin
        if (pcpi_wait) begin
          timeout_cnt <= '0;
        end else if (!pcpi_ready) begin
          timeout_cnt <= timeout_cnt + 8'd1;
        end
      end
      resp_trap <= timeout_hit;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign resp_trap   = 1'b0;
  assign unused_cfg  = pcpi_wait ^ (TIMEOUT_CYCLES > 1);
`endif

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Randomised scoreboard bench for pcpi_issue_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever resp_valid is seen.
module tb_pcpi_issue_ctrl;

  localparam int TO = 16;
  localparam int M_READY = 0;
  localparam int M_WAIT = 1;
  localparam int M_FLUSH = 2;
  localparam int M_FLUSH_RDY = 3;
  localparam int M_SILENT = 4;
  localparam int M_RESET = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        req_ready;
  logic        flush;
  logic        resp_valid, resp_wr, resp_trap;
  logic [31:0] resp_rd;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  typedef struct packed {
    logic        wr;
    logic        trap;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] last_rd;
  int          total = 0;
  int          bad = 0;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready), .flush(flush),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_trap(resp_trap), .resp_rd(resp_rd),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Every completion must match the oldest outstanding expectation; idle cycles must stay quiet.
  always @(negedge clk) begin
    if (resetn) begin
      if (resp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL spurious_resp: got wr=%0b trap=%0b rd=%0h want=none",
                   resp_wr, resp_trap, resp_rd);
        end else begin
          mon_e = exp_q.pop_front();
          if ({resp_wr, resp_trap, resp_rd} !== mon_e) begin
            bad++;
            $display("[TB] FAIL resp: got wr=%0b trap=%0b rd=%0h want wr=%0b trap=%0b rd=%0h",
                     resp_wr, resp_trap, resp_rd, mon_e.wr, mon_e.trap, mon_e.rd);
          end
        end
      end else begin
        checkOutput("idle_resp_flags", 32'({resp_wr, resp_trap}), 32'd0);
      end
    end
  end

  task automatic doAccept(input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic fl);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    flush     = fl;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    req_insn  = $urandom;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    checkOutput("issue_valid", 32'(pcpi_valid), 32'd1);
    checkOutput("issue_insn", pcpi_insn, insn);
    checkOutput("issue_rs1", pcpi_rs1, rs1);
    checkOutput("issue_rs2", pcpi_rs2, rs2);
  endtask

  task automatic issueCycles(input int lat, input logic [31:0] insn, input logic wait_all);
    for (int k = 0; k < lat; k++) begin
      checkOutput("hold_valid", 32'(pcpi_valid), 32'd1);
      checkOutput("hold_insn", pcpi_insn, insn);
      pcpi_wait = wait_all ? 1'b1 : 1'($urandom_range(0, 1));
      pcpi_wr   = 1'($urandom_range(0, 1));
      pcpi_rd   = $urandom;
      @(negedge clk);
    end
    pcpi_wait = 1'b0;
  endtask

  task automatic applyStimulus(input int mode, input int lat, input logic [31:0] insn,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic wr, input logic [31:0] rd, input logic fl);
    int n;
    doAccept(insn, rs1, rs2, fl);
    case (mode)
      M_READY, M_WAIT: begin
        issueCycles(lat, insn, mode == M_WAIT);
        checkOutput("pre_ready_valid", 32'(pcpi_valid), 32'd1);
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        exp_q.push_back('{wr: wr, trap: 1'b0, rd: rd});
        last_rd = rd;
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_rd    = $urandom;
        flush      = fl;
        checkOutput("done_valid_low", 32'(pcpi_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("back_idle_ready", 32'(req_ready), 32'd1);
      end
      M_FLUSH, M_FLUSH_RDY: begin
        issueCycles(lat, insn, 1'b0);
        flush      = 1'b1;
        pcpi_ready = (mode == M_FLUSH_RDY);
        pcpi_wr    = 1'b1;
        pcpi_rd    = $urandom;
        @(negedge clk);
        flush      = 1'b0;
        pcpi_ready = 1'b0;
        checkOutput("flush_valid_low", 32'(pcpi_valid), 32'd0);
        checkOutput("flush_ready", 32'(req_ready), 32'd1);
      end
      M_SILENT: begin
`ifdef PCPI_TIMEOUT_EN
        exp_q.push_back('{wr: 1'b0, trap: 1'b1, rd: last_rd});
        n = 0;
        while (pcpi_valid && n < 400) begin
          n++;
          pcpi_wait = (n <= lat);
          @(negedge clk);
        end
        pcpi_wait = 1'b0;
        checkOutput("timeout_len", 32'(n), 32'(lat + TO));
        @(negedge clk);
`else
        n = 0;
        for (int k = 0; k < 40; k++) begin
          if (pcpi_valid) n++;
          pcpi_wait = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        pcpi_wait = 1'b0;
        checkOutput("silent_len", 32'(n), 32'd40);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("silent_flush_low", 32'(pcpi_valid), 32'd0);
`endif
      end
      default: begin
        issueCycles(lat, insn, 1'b0);
        resetn = 1'b0;
        #1;
        checkOutput("rst_valid_low", 32'(pcpi_valid), 32'd0);
        checkOutput("rst_resp_rd", resp_rd, 32'd0);
        checkOutput("rst_insn", pcpi_insn, 32'd0);
        last_rd = '0;
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
      end
    endcase
  endtask

  // Back-to-back requests with req_valid and pcpi_ready held high show the minimum spacing.
  task automatic heldRequests();
    logic [31:0] cur_insn;
    logic [31:0] r;
    int guard;
    r = $urandom;
    cur_insn = '0;
    req_valid  = 1'b1;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = r;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 15; c++) begin
      checkOutput("held_ready_pattern", 32'(req_ready), 32'((c % 3) == 0));
      if ((c % 3) == 0) begin
        cur_insn = $urandom;
        req_insn = cur_insn;
        exp_q.push_back('{wr: 1'b1, trap: 1'b0, rd: r});
        last_rd = r;
      end else if ((c % 3) == 1) begin
        checkOutput("held_issue_insn", pcpi_insn, cur_insn);
      end
      @(negedge clk);
    end
    req_valid  = 1'b0;
    pcpi_ready = 1'b0;
  endtask

  initial begin
    int mode;
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_insn   = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    flush      = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    last_rd    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_pcpi_valid", 32'(pcpi_valid), 32'd0);
    checkOutput("reset_resp", 32'({resp_valid, resp_wr, resp_trap}), 32'd0);
    checkOutput("reset_resp_rd", resp_rd, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(M_READY, 5, 32'h02B50533, 32'd7, 32'd6, 1'b1, 32'd42, 1'b0);
    applyStimulus(M_WAIT, 100, $urandom, $urandom, $urandom, 1'b1, 32'hFFFFFFFF, 1'b0);
    applyStimulus(M_FLUSH_RDY, 2, $urandom, $urandom, $urandom, 1'b1, 32'd0, 1'b0);
    applyStimulus(M_SILENT, 0, $urandom, $urandom, $urandom, 1'b0, 32'd0, 1'b0);
    applyStimulus(M_RESET, 3, $urandom, $urandom, $urandom, 1'b0, 32'd0, 1'b0);
    applyStimulus(M_READY, 2, 32'h02B50533, 32'd7, 32'd6, 1'b1, 32'd42, 1'b1);
    heldRequests();

    $display("[TB] random transactions");
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 5) mode = M_READY;
      else if (mode == 6) mode = M_FLUSH;
      else if (mode == 7) mode = M_FLUSH_RDY;
      else if (mode == 8) mode = M_SILENT;
      else mode = M_RESET;
      applyStimulus(mode, int'($urandom_range(0, 10)), $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
